serial_sub8bit: RTL



---
 rtl/serial_sub8bit.sv | 113 +++++++++++
 1 files changed

// File: rtl/serial_sub8bit.sv
// Bit-serial subtractor: Diff = A - B - Bin, one bit per clock LSB first through a single full-subtractor cell.
// Latency WIDTH clocks from accepting start to done; start is ignored while busy (no queuing, no stall).
module serial_sub8bit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout,
   output logic             Ovf
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q, br_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;

   logic a_bit, b_bit, d_bit, br_nxt;

   always_comb begin
      a_bit  = a_sh_q[0];
      b_bit  = b_sh_q[0];
      d_bit  = a_bit ^ b_bit ^ br_q;
      br_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
   end

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      br_d    = br_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               a_sh_d  = A;
               b_sh_d  = B;
               br_d    = Bin;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            res_d  = {d_bit, res_q[WIDTH-1:1]};
            br_d   = br_nxt;
            cnt_d  = cnt_q + CW'(1);
            // On the MSB cycle br_q is the borrow into the sign bit, br_nxt the borrow out of it.
            if (cnt_q == LAST) begin
               state_d = DONE;
               diff_d  = {d_bit, res_q[WIDTH-1:1]};
               bout_d  = br_nxt;
               ovf_d   = br_q ^ br_nxt;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         br_q    <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         br_q    <= br_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign Diff = diff_q;
   assign Bout = bout_q;
   assign Ovf  = ovf_q;

endmodule
